f64_div_seq: RTL and testbench

//  Iterative IEEE-754 binary64 divider, out = x / y. It is the inverse companion of the combinational f64 multiplier.

---
 rtl/f64_pkg.sv | 25 ++
 rtl/f64_round_pack.sv | 58 +++++
 rtl/f64_div_seq.sv | 201 ++++++++++++++++++++
 tb/tb_f64_div_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/f64_pkg.sv
// f64_pkg: shared binary64 definitions for the divider and its companion
// multiplier.
//   EXP_W / FRAC_W / BIAS : binary64 field widths and exponent bias
//   QNAN                  : canonical quiet NaN produced for invalid operations
//   fp_class_e            : operand special-class code (subnormals classify as ZERO)
//   div_state_e           : sequencing states of the iterative divider
//   classify()            : maps a raw binary64 word to its special class
package f64_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int BIAS   = 1023;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {NORM, ZERO, INF, NAN} fp_class_e;
  typedef enum logic [1:0] {IDLE, CALC, ROUND, HOLD} div_state_e;

  // Biased exponent 0 covers both true zero and subnormals (flush-to-zero).
  function automatic fp_class_e classify(input logic [63:0] v);
    if (v[62 -: EXP_W] == '0) return ZERO;
    if (v[62 -: EXP_W] == '1) return (v[FRAC_W-1:0] == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/f64_round_pack.sv
// f64_round_pack: combinational round-to-nearest-even, exponent clamp and
// binary64 field packing for a normalised 53-bit significand.
//   sign      in   result sign
//   exp_in    in   biased exponent before rounding, 13-bit signed
//   mant      in   normalised significand, mant[52] is the implicit 1
//   guard     in   first bit below the LSB of mant
//   sticky    in   OR of everything below guard
//   result    out  packed binary64 (+/-inf on overflow, +/-0 on underflow)
// Macro F64DIV_EXC_FLAGS_EN adds overflow / underflow / inexact outputs.
module f64_round_pack (
  input  logic               sign,
  input  logic signed [12:0] exp_in,
  input  logic [52:0]        mant,
  input  logic               guard,
  input  logic               sticky,
  output logic [63:0]        result
`ifdef F64DIV_EXC_FLAGS_EN
  ,
  output logic               overflow,
  output logic               underflow,
  output logic               inexact
`endif
);

  logic               round_up;
  logic [53:0]        sum;
  logic               carry;
  logic [51:0]        frac;
  logic signed [12:0] exp_final;
  logic               ovf;
  logic               unf;

  assign round_up = guard & (sticky | mant[0]);
  assign sum      = {1'b0, mant} + {53'd0, round_up};
  // A carry out of the significand means it rounded up to exactly 2.0,
  // so the fraction becomes zero and the exponent moves up by one.
  assign carry     = sum[53];
  assign frac      = carry ? sum[52:1] : sum[51:0];
  assign exp_final = exp_in + $signed({12'd0, carry});
  assign ovf       = (exp_final >= 13'sd2047);
  assign unf       = (exp_final <= 13'sd0);

  always_comb begin
    result = {sign, exp_final[10:0], frac};
    if (ovf) begin
      result = {sign, 11'h7FF, 52'd0};
    end else if (unf) begin
      result = {sign, 63'd0};
    end
  end

`ifdef F64DIV_EXC_FLAGS_EN
  assign overflow  = ovf;
  assign underflow = unf;
  assign inexact   = guard | sticky | ovf | unf;
`endif

endmodule

// File: rtl/f64_div_seq.sv
// f64_div_seq: iterative binary64 divider, out = x / y, FTZ + RNE.
// One division in flight; operands enter and the quotient leaves over
// valid/ready handshakes.
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready operand handshake (x dividend, y divisor)
//   out_valid/out_ready result handshake, out held stable under backpressure
//   flags[4:0]          {invalid, div_by_zero, overflow, underflow, inexact},
//                       present only when F64DIV_EXC_FLAGS_EN is defined
// BITS_PER_CYCLE (1, 5 or 11) quotient bits are retired per CALC cycle.
module f64_div_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out
`ifdef F64DIV_EXC_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  import f64_pkg::*;

  localparam int QW = 55;
  localparam int N  = QW / BITS_PER_CYCLE;

  div_state_e         state_reg, state_next;
  logic [5:0]         cnt_reg;
  logic               sign_reg;
  logic signed [12:0] exp_reg;
  logic [52:0]        div_reg;
  logic [53:0]        rem_reg;
  logic [QW-1:0]      q_reg;
  logic [63:0]        out_reg;

  logic               accept;
  fp_class_e          cls_x, cls_y;
  logic               sgn;
  logic               special;
  logic [63:0]        special_out;

  assign cls_x   = classify(x);
  assign cls_y   = classify(y);
  assign sgn     = x[63] ^ y[63];
  assign special = (cls_x != NORM) || (cls_y != NORM);

  always_comb begin
    special_out = {sgn, 63'd0};
    if (cls_x == NAN || cls_y == NAN || (cls_x == ZERO && cls_y == ZERO) ||
        (cls_x == INF && cls_y == INF)) begin
      special_out = QNAN;
    end else if (cls_x == INF || cls_y == ZERO) begin
      special_out = {sgn, 11'h7FF, 52'd0};
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          state_next = special ? HOLD : CALC;
        end
      end
      CALC: begin
        if (cnt_reg == 6'(N - 1)) begin
          state_next = ROUND;
        end
      end
      ROUND: state_next = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // ---------------- restoring division steps ----------------
  // The partial remainder is always below the divisor after a step, so
  // shifting it left by one never loses a set bit.
  logic [53:0]               rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign rem_chain[0] = rem_reg;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [54:0] diff;
    logic [53:0] sel;
    assign diff = {1'b0, rem_chain[gi]} - {2'b00, div_reg};
    assign sel  = diff[54] ? rem_chain[gi] : diff[53:0];
    assign q_bits[BITS_PER_CYCLE-1-gi] = ~diff[54];
    assign rem_chain[gi+1] = sel << 1;
  end

  // ---------------- normalise + round ----------------
  // q = floor(mx * 2^54 / my) lies in (2^53, 2^55): the leading one is in
  // bit 54 or bit 53.
  logic               norm;
  logic [52:0]        mant;
  logic               guard;
  logic               sticky;
  logic signed [12:0] exp_in;
  logic [63:0]        rp_result;

  assign norm   = q_reg[54];
  assign mant   = norm ? q_reg[54:2] : q_reg[53:1];
  assign guard  = norm ? q_reg[1] : q_reg[0];
  assign sticky = (rem_reg != '0) | (norm & q_reg[0]);
  assign exp_in = norm ? exp_reg : exp_reg - 13'sd1;

`ifdef F64DIV_EXC_FLAGS_EN
  logic       rp_ovf, rp_unf, rp_inexact;
  logic [4:0] flags_reg;
`endif

  f64_round_pack u_round_pack (
    .sign      (sign_reg),
    .exp_in    (exp_in),
    .mant      (mant),
    .guard     (guard),
    .sticky    (sticky),
    .result    (rp_result)
`ifdef F64DIV_EXC_FLAGS_EN
    ,
    .overflow  (rp_ovf),
    .underflow (rp_unf),
    .inexact   (rp_inexact)
`endif
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      cnt_reg   <= '0;
`ifdef F64DIV_EXC_FLAGS_EN
      flags_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sign_reg <= sgn;
            exp_reg  <= $signed({2'b00, x[62:52]}) - $signed({2'b00, y[62:52]}) + 13'(BIAS);
            div_reg  <= {1'b1, y[51:0]};
            rem_reg  <= {2'b01, x[51:0]};
            cnt_reg  <= '0;
            if (special) begin
              out_reg <= special_out;
`ifdef F64DIV_EXC_FLAGS_EN
              flags_reg <= {((cls_x == ZERO && cls_y == ZERO) || (cls_x == INF && cls_y == INF)),
                            (cls_x == NORM && cls_y == ZERO), 3'b000};
`endif
            end
          end
        end
        CALC: begin
          rem_reg <= rem_chain[BITS_PER_CYCLE];
          q_reg   <= {q_reg[QW-1-BITS_PER_CYCLE:0], q_bits};
          cnt_reg <= cnt_reg + 6'd1;
        end
        ROUND: begin
          out_reg <= rp_result;
`ifdef F64DIV_EXC_FLAGS_EN
          flags_reg <= {2'b00, rp_ovf, rp_unf, rp_inexact};
`endif
        end
        default: ;
      endcase
    end
  end

  assign out = out_reg;
`ifdef F64DIV_EXC_FLAGS_EN
  assign flags = flags_reg;
`endif

endmodule

// File: tb/tb_f64_div_seq.sv
// Testbench for f64_div_seq: directed corner cases, backpressure, mid-run
// reset and randomized operands against a real-arithmetic reference model.
// Expected results go into a scoreboard queue; a monitor on the falling edge
// compares whatever the DUT presents.
module tb_f64_div_seq;

  localparam int BPC      = 1;
  localparam int NORM_LAT = 55 / BPC + 2;
  localparam logic [63:0] CQNAN = 64'h7FF8_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x = '0;
  logic [63:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out;
`ifdef F64DIV_EXC_FLAGS_EN
  logic [4:0]  flags;
`endif

  f64_div_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef F64DIV_EXC_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit rand_bp = 1'b0;
  bit seen = 1'b0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  fl;
    bit          fl_chk;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic void check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic bit is_special(input logic [63:0] a, input logic [63:0] b);
    return (a[62:52] == 11'd0) || (a[62:52] == 11'h7FF) ||
           (b[62:52] == 11'd0) || (b[62:52] == 11'h7FF);
  endfunction

  // Reference: specials by rule; finite case divides the two significands
  // as doubles in [1,2) (exact RNE at 53 bits) and re-applies the exponent
  // difference, then clamps to inf / flushes to zero.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [10:0] ae, be;
    logic [63:0] rb;
    bit an, bn, ai, bi, az, bz;
    logic s;
    real as_r, bs_r;
    int e;
    ae = a[62:52];
    be = b[62:52];
    s  = a[63] ^ b[63];
    az = (ae == 11'd0);
    bz = (be == 11'd0);
    ai = (ae == 11'h7FF) && (a[51:0] == 52'd0);
    bi = (be == 11'h7FF) && (b[51:0] == 52'd0);
    an = (ae == 11'h7FF) && (a[51:0] != 52'd0);
    bn = (be == 11'h7FF) && (b[51:0] != 52'd0);
    if (an || bn || (az && bz) || (ai && bi)) return CQNAN;
    if (ai || bz) return {s, 11'h7FF, 52'd0};
    if (az || bi) return {s, 63'd0};
    as_r = $bitstoreal({12'h3FF, a[51:0]});
    bs_r = $bitstoreal({12'h3FF, b[51:0]});
    rb = $realtobits(as_r / bs_r);
    e = int'(rb[62:52]) - 1023 + int'(ae) - int'(be) + 1023;
    if (e >= 2047) return {s, 11'h7FF, 52'd0};
    if (e <= 0) return {s, 63'd0};
    return {s, e[10:0], rb[51:0]};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    int sel;
    v = {$urandom, $urandom};
    sel = $urandom_range(0, 11);
    case (sel)
      0: v[62:52] = 11'd0;
      1: begin v[62:52] = 11'h7FF; v[51:0] = 52'd0; end
      2: v[62:52] = 11'h7FF;
      default: v[62:52] = 11'($urandom_range(1, 2046));
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] res,
                      input logic [4:0] fl, input bit fl_chk);
    exp_t e;
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    x = a;
    y = b;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = res;
        e.fl = fl;
        e.fl_chk = fl_chk;
        e.acc = cyc;
        e.lat = is_special(a, b) ? 1 : NORM_LAT;
        sb.push_back(e);
        got = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!got) check64("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (sb.size() > 0) check64("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: result and latency checked when out_valid rises, value checked
  // again at the handshake before the entry is retired.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            check64("unexpected_valid", {63'd0, out_valid}, 64'd0);
          end else begin
            check64("result", out, sb[0].res);
            check64("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
`ifdef F64DIV_EXC_FLAGS_EN
            if (sb[0].fl_chk) check64("flags", {59'd0, flags}, {59'd0, sb[0].fl});
`endif
          end
        end
        if (out_ready) begin
          if (sb.size() > 0) begin
            check64("held_result", out, sb[0].res);
            void'(sb.pop_front());
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check64("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check64("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check64("reset_out", out, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check64("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    // Directed cases
    send(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 1'b1);
    send(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001, 1'b1);
    send(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'b01000, 1'b1);
    send(64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'b10000, 1'b1);
    send(64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000, 5'b00000, 1'b1);
    send(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'b00101, 1'b1);
    send(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'b00011, 1'b1);
    send(64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'b10000, 1'b1);
    send(64'hC000000000000000, 64'h7FF0000000000000, 64'h8000000000000000, 5'b00000, 1'b1);
    wait_drain();

    // Backpressure: result held 20 cycles, competing operands not accepted
    out_ready = 1'b0;
    send(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 1'b1);
    for (int i = 0; i < 200 && !out_valid; i++) tick();
    in_valid = 1'b1;
    x = 64'h3FF0000000000000;
    y = 64'h0000000000000000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check64("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check64("bp_out", out, 64'h4008000000000000);
      check64("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (70) tick();

    // Reset in the middle of CALC discards the operation
    send(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 1'b1);
    repeat (29) tick();
    rst = 1'b1;
    @(negedge clk);
    check64("rst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    sb.delete();
    tick();
    @(negedge clk);
    check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check64("rst_out", out, 64'd0);
    tick();
    rst = 1'b0;
    send(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 1'b1);
    wait_drain();

    // Randomized operands with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = rand_op();
      b = rand_op();
      send(a, b, model(a, b), 5'b00000, 1'b0);
    end
    wait_drain();
    rand_bp = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
